// File: rtl/irq_sched.sv
// Fixed-priority interrupt scheduler: pending/enable registers and an IDLE/REQ/SERVICE handshake
// with the core. Define IRQ_SCHED_EDGE_EN for edge-triggered pending; default is level mode.
module irq_sched #(
  parameter int unsigned NUM_SRC = 8,
  localparam int unsigned ID_W = $clog2(NUM_SRC)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic               cfg_we,
  input  logic [NUM_SRC-1:0] cfg_wdata,
  output logic [NUM_SRC-1:0] cfg_rdata,
  output logic [NUM_SRC-1:0] pending,
  output logic               interupt,
  output logic [ID_W-1:0]    irq_id,
  input  logic               irq_ack,
  input  logic               irq_done
);

  typedef enum logic [1:0] {StIdle, StReq, StService} state_e;

  state_e               state_q, state_d;
  logic [NUM_SRC-1:0]   src_q, src_d;
  logic [NUM_SRC-1:0]   pending_q, pending_d;
  logic [NUM_SRC-1:0]   enable_q, enable_d;
  logic [ID_W-1:0]      irq_id_q, irq_id_d;
  logic                 interupt_q, interupt_d;
  logic [NUM_SRC-1:0]   cand;
  logic [ID_W-1:0]      win_id;

  assign cand = pending_q & enable_q;

  // Lowest index wins: scan downwards so the last hit is the smallest set bit.
  always_comb begin
    win_id = '0;
    for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
      if (cand[i]) win_id = ID_W'(i);
    end
  end

  always_comb begin
    src_d    = irq_src;
    enable_d = cfg_we ? cfg_wdata : enable_q;
  end

`ifdef IRQ_SCHED_EDGE_EN
  logic [NUM_SRC-1:0] set_vec;
  logic [NUM_SRC-1:0] clr_vec;

  // A fresh rising edge on the acknowledged source must not be lost, so set overrides clear.
  always_comb begin
    set_vec = irq_src & ~src_q;
    clr_vec = '0;
    if (state_q == StReq && irq_ack) clr_vec[irq_id_q] = 1'b1;
    pending_d = (pending_q & ~clr_vec) | set_vec;
  end
`else
  // Level mode: pending mirrors the sampled source and is never cleared by acknowledge.
  always_comb begin
    pending_d = src_d;
  end
`endif

  always_comb begin
    state_d  = state_q;
    irq_id_d = irq_id_q;
    unique case (state_q)
      StIdle: begin
        if (|cand) begin
          state_d  = StReq;
          irq_id_d = win_id;
        end
      end
      StReq: begin
        if (irq_ack) begin
          state_d = StService;
        end else if (!enable_q[irq_id_q]) begin
          state_d = StIdle;
        end
      end
      StService: begin
        if (irq_done) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    interupt_d = (state_d == StReq);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      src_q      <= '0;
      pending_q  <= '0;
      enable_q   <= '1;
      irq_id_q   <= '0;
      interupt_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      pending_q  <= pending_d;
      enable_q   <= enable_d;
      irq_id_q   <= irq_id_d;
      interupt_q <= interupt_d;
    end
  end

  assign cfg_rdata = enable_q;
  assign pending   = pending_q;
  assign interupt  = interupt_q;
  assign irq_id    = irq_id_q;

endmodule
